alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Round-robin scheduler that shares one combinational ALU (4-bit function code, two 32-bit operands, 32-bit result) among NREQ requesters, for example the integer execute path and the branch-compare path.
- Each requester uses a valid/ready request handshake. The block registers the operands, drives the shared ALU for one cycle and captures the result.
- The result is returned on a single response channel with a requester ID and valid/ready backpressure.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept strobe; at most one bit set.
- req_funct  input  4*NREQ  packed ALU function codes; requester i at [4i+3:4i].
- req_a  input  32*NREQ  packed operand A; requester i at [32i+31:32i].
- req_b  input  32*NREQ  packed operand B, same packing.
- alu_funct  output  4  function code to the shared ALU.
- alu_a  output  32  operand A to the shared ALU.
- alu_b  output  32  operand B to the shared ALU.
- alu_result  input  32  combinational result from the shared ALU.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer ready.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_result  output  32  captured ALU result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, including alu_funct/alu_a/alu_b and the rsp_* outputs. State is IDLE and the round-robin pointer rr_ptr is 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, no req_valid bit set: remain in IDLE; req_ready = 0.
- IDLE, one or more req_valid bits set:
  - Winner = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[winner] = 1 combinationally in this cycle only.
  - On the clock edge, latch funct/a/b into the operand registers and the winner index into the id register.
  - rr_ptr <= (winner+1) mod NREQ.
  - Next state EXEC.
- EXEC: the operand registers drive alu_funct/alu_a/alu_b. On the clock edge, rsp_result <= alu_result. Next state RESP.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_result are held stable.
  - If rsp_ready = 1, the handshake completes on the edge and the next state is IDLE.
  - If rsp_ready = 0, stay in RESP indefinitely.
- Latency: accept edge -> rsp_valid high 2 cycles later. Minimum issue interval is 3 cycles per operation.
- Outside IDLE, req_ready = 0. Requesters hold valid and payload until accepted. A request dropped before acceptance is ignored without error.
- The ALU operand registers hold their last values outside EXEC. They are not cleared, to avoid toggling.
- Function codes pass through untouched; the arbiter does not decode them. An undefined code yields whatever the ALU returns (0 for its default case).
- The rsp_ready value outside RESP is ignored.
- Simultaneous requests: exactly one is granted. A requester that keeps requesting while others are waiting is served at most once per NREQ grants (starvation-free).
- rr_ptr wraps from NREQ-1 to 0.
- Reset asserted mid-operation: immediately returns to the reset state. Any in-flight operation and its response are discarded.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined: adds output busy_cnt (32 bits).
  - Increments every cycle the FSM is not in IDLE.
  - Saturates at 0xFFFF_FFFF.
  - Cleared to 0 by reset.
- Undefined: the busy_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req_valid=2'b01, funct=ALU_SUB, a=5, b=3.
  - req_ready=2'b01 for one cycle.
  - alu_a=5, alu_b=3 in the following cycle.
  - rsp_valid=1 with rsp_id=0, rsp_result=2 two cycles after accept.
- Contention: both requesters valid continuously from reset (req0 ALU_ADD 1+1, req1 ALU_XOR 0xF0^0xFF).
  - Grant order is 0,1,0,1.
  - Responses alternate id 0 (result 2) and id 1 (result 0x0F).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_id and rsp_result stay constant.
  - req_ready stays 0 despite pending requests.
  - When rsp_ready=1, the next grant occurs in the following cycle.
- Signed/shift path: ALU_SRA with a=0x8000_0000, b=0x21 -> rsp_result=0xC000_0000 (shift amount 1).
- Reset mid-operation: assert rst_n=0 during EXEC.
  - All outputs go to 0 asynchronously.
  - After release, the first grant goes to requester 0 (rr_ptr reset).
- With ALU_ARB_PERF_EN: one uncontended operation with rsp_ready tied 1 -> busy_cnt=2 afterwards; reset clears it to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Optional: define ALU_ARB_PERF_EN to add the saturating busy_cnt output.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_funct,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [3:0]           alu_funct,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]          busy_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q;
    logic [3:0]     funct_q;
    logic [31:0]    a_q, b_q, result_q;

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  winner;
    logic            found;
    logic            grant;

    // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        rot    = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        found  = 1'b0;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    req_ready = NREQ'(1) << winner;
                    rr_ptr_d  = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            funct_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            // Operand registers are only loaded on a grant so the ALU inputs stay quiet otherwise.
            if (grant) begin
                id_q    <= winner;
                funct_q <= req_funct[4*int'(winner) +: 4];
                a_q     <= req_a[32*int'(winner) +: 32];
                b_q     <= req_b[32*int'(winner) +: 32];
            end
            if (state_q == EXEC) result_q <= alu_result;
        end
    end

    assign alu_funct  = funct_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (state_q != IDLE && busy_q != 32'hFFFF_FFFF) begin
            busy_q <= busy_q + 32'd1;
        end
    end

    assign busy_cnt = busy_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus randomized requests vs. a behavioural model.
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 2;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_funct = '0;
    logic [32*NREQ-1:0]  req_a = '0;
    logic [32*NREQ-1:0]  req_b = '0;
    logic [3:0]          alu_funct;
    logic [31:0]         alu_a, alu_b, alu_result;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_result;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]         busy_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int ptr   = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
`ifdef ALU_ARB_PERF_EN
        , .busy_cnt(busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return sa >>> b[4:0];
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_funct, alu_a, alu_b);

    function automatic int model_winner(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = v;
        req_funct[4*i +: 4] = f;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    task automatic check_zero(input string tag);
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_alu_funct"}, 32'(alu_funct), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
`ifdef ALU_ARB_PERF_EN
        chk({tag, "_busy_cnt"}, busy_cnt, 32'd0);
`endif
    endtask

    // Entry: just after a rising edge, DUT idle, request inputs already driven.
    task automatic run_op(input int hold, input logic drop, output int w, output logic [31:0] got_res);
        logic [NREQ-1:0] oh;
        logic [3:0]      f;
        logic [31:0]     a, b, exp_r;
        w = model_winner(req_valid);
        got_res = '0;
        #1;
        if (w < 0) begin
            chk("no_request_to_grant", 32'd0, 32'd1);
            return;
        end
        oh = '0;
        oh[w] = 1'b1;
        chk("grant", 32'(req_ready), 32'(oh));
        f = req_funct[4*w +: 4];
        a = req_a[32*w +: 32];
        b = req_b[32*w +: 32];
        exp_r = alu_model(f, a, b);
        rsp_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #2;
        ptr = (w + 1) % NREQ;
        if (drop) req_valid[w] = 1'b0;
        #1;
        chk("exec_funct", 32'(alu_funct), 32'(f));
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_id", 32'(rsp_id), 32'(w));
            chk("hold_result", rsp_result, exp_r);
            chk("hold_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #2;
        end
        rsp_ready = 1'b1;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(w));
        chk("rsp_result", rsp_result, exp_r);
        chk("rsp_ready_block", 32'(req_ready), 32'd0);
        got_res = rsp_result;
        @(posedge clk); #2;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int          w;
        logic [31:0] r;

        // Reset state and idle without requests
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #2;
        #1;
        chk("idle_noreq", 32'(req_ready), 32'd0);

        // Single request: 5 - 3
        set_req(0, 1'b1, ALU_SUB, 32'd5, 32'd3);
        run_op(0, 1'b1, w, r);
        chk("single_id", 32'(w), 32'd0);
        chk("single_result", r, 32'd2);
`ifdef ALU_ARB_PERF_EN
        #1;
        chk("busy_after_one", busy_cnt, 32'd2);
`endif

        // Contention from reset
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        ptr = 0;
        @(posedge clk); #2;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, ALU_XOR, 32'hF0, 32'hFF);
        for (int k = 0; k < 4; k++) begin
            run_op(0, 1'b0, w, r);
            chk("contend_order", 32'(w), 32'(k % 2));
            chk("contend_result", r, (k % 2 == 0) ? 32'd2 : 32'h0F);
        end

        // Backpressure then immediate regrant
        run_op(5, 1'b0, w, r);
        run_op(0, 1'b0, w, r);

        // Arithmetic shift, shift amount taken from b[4:0]
        req_valid = '0;
        set_req(1, 1'b1, ALU_SRA, 32'h8000_0000, 32'h21);
        run_op(0, 1'b1, w, r);
        chk("sra_result", r, 32'hC000_0000);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_op($urandom_range(0, 3), 1'b1, w, r);
        end

        // Reset during EXEC
        req_valid = '0;
        set_req(0, 1'b1, ALU_ADD, 32'd7, 32'd9);
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        req_valid = '0;
        #1;
        chk("pre_rst_exec_a", alu_a, 32'd7);
        rst_n = 1'b0;
        ptr = 0;
        check_zero("async_rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        set_req(0, 1'b1, ALU_OR, 32'h10, 32'h01);
        set_req(1, 1'b1, ALU_AND, 32'hFF, 32'h0F);
        run_op(0, 1'b1, w, r);
        chk("post_rst_first_id", 32'(w), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
